// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output arbiters: router port indices
// and the lock state encoding.
package noc_arb_pkg;

    localparam int PORT_N        = 0;
    localparam int PORT_S        = 1;
    localparam int PORT_W        = 2;
    localparam int PORT_E        = 3;
    localparam int PORT_L        = 4;
    localparam int NOC_NUM_PORTS = 5;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority pick: first set bit of i_desire at or after i_rr_ptr,
// wrapping modulo NUM_PORTS. The desire vector is doubled so that the wrap
// becomes a plain lowest-set-bit search above the pointer.
module rr_pick
    import noc_arb_pkg::*;
#(
    parameter int NUM_PORTS = NOC_NUM_PORTS,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_desire,
    input  logic [IDX_W-1:0]     i_rr_ptr,
    output logic                 o_found,
    output logic [IDX_W-1:0]     o_winner
);

    logic [2*NUM_PORTS-1:0] w_dbl;
    logic [2*NUM_PORTS-1:0] w_cand;

    // Double the vector and mask off positions below the pointer.
    always_comb begin
        w_dbl = {i_desire, i_desire};
        for (int j = 0; j < 2*NUM_PORTS; j++) begin
            w_cand[j] = w_dbl[j] && (j >= int'(i_rr_ptr));
        end
    end

    // Lowest surviving bit wins; fold the upper copy back onto 0..NUM_PORTS-1.
    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        for (int j = 0; j < 2*NUM_PORTS; j++) begin
            if (!o_found && w_cand[j]) begin
                o_found  = 1'b1;
                o_winner = (j >= NUM_PORTS) ? IDX_W'(j - NUM_PORTS) : IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/rr_output_arbiter.sv
// Round-robin arbiter for one output leg of the router crossbar, with
// packet-level locking and a downstream credit counter.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_UNLOCKED | between packets; winner chosen round-robin from rr_ptr
// ST_LOCKED   | mid-packet; only r_owner may be granted until its tail flit
module rr_output_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_PORTS    = NOC_NUM_PORTS,
    parameter int PORT_ID      = PORT_W,
    parameter int ADDR_W       = 3,
    parameter int CREDIT_DEPTH = 4,
    parameter int IDX_W        = $clog2(NUM_PORTS),
    parameter int CRED_W       = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req_valid_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_nexthop_addr_i,
    input  logic [NUM_PORTS-1:0]        req_tail_i,
    input  logic                        downstream_credit_i,
    output logic [NUM_PORTS-1:0]        grant_onehot_o,
    output logic [IDX_W-1:0]            grant_idx_o,
    output logic                        grant_valid_o,
    output logic [CRED_W-1:0]           credit_count_o,
    output logic                        locked_o,
    output logic                        credit_overflow_o
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_owner;
    logic [CRED_W-1:0] r_credits;
    logic              r_overflow;

    logic [NUM_PORTS-1:0] w_desire;
    logic                 w_found;
    logic [IDX_W-1:0]     w_pick;
    logic [IDX_W-1:0]     w_win;
    logic                 w_can_send;
    logic                 w_grant;
    logic                 w_win_tail;

    // An input wants this output if it is valid, addressed here, and not a U-turn.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_desire[i] = req_valid_i[i]
                       && (req_nexthop_addr_i[i*ADDR_W +: ADDR_W] == ADDR_W'(PORT_ID))
                       && (i != PORT_ID);
        end
    end

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .i_desire  (w_desire),
        .i_rr_ptr  (r_rr_ptr),
        .o_found   (w_found),
        .o_winner  (w_pick)
    );

    // Winner selection: the locked owner, otherwise the round-robin pick.
    always_comb begin
        w_can_send = (r_credits != '0);
        w_win      = (r_state == ST_LOCKED) ? r_owner : w_pick;
        w_grant    = !reset && w_can_send
                  && ((r_state == ST_LOCKED) ? w_desire[r_owner] : w_found);
        w_win_tail = req_tail_i[w_win];
    end

    // Lock FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock FSM next state: a non-tail transfer locks, a tail transfer unlocks.
    always_comb begin
        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = w_win_tail ? ST_UNLOCKED : ST_LOCKED;
        end
    end

    // Outputs; reset forces the idle crossbar default immediately.
    always_comb begin
        grant_onehot_o = '0;
        if (w_grant) begin
            grant_onehot_o[w_win] = 1'b1;
        end
        grant_valid_o     = w_grant;
        grant_idx_o       = w_grant ? w_win : IDX_W'(PORT_ID);
        locked_o          = !reset && (r_state == ST_LOCKED);
        credit_count_o    = reset ? CRED_W'(CREDIT_DEPTH) : r_credits;
        credit_overflow_o = !reset && r_overflow;
    end

    // Owner, round-robin pointer, credit counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_credits  <= CRED_W'(CREDIT_DEPTH);
            r_overflow <= 1'b0;
        end else begin
            if (w_grant) begin
                if (w_win_tail) begin
                    r_rr_ptr <= (w_win == IDX_W'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
                end else begin
                    r_owner <= w_win;
                end
            end
            case ({w_grant, downstream_credit_i})
                2'b10: r_credits <= r_credits - 1'b1;
                2'b01: begin
                    if (r_credits == CRED_W'(CREDIT_DEPTH)) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_credits <= r_credits + 1'b1;
                    end
                end
                default: r_credits <= r_credits;
            endcase
        end
    end

endmodule

// File: doc/rr_output_arbiter.md
Name: rr_output_arbiter

Overview:
Parametrised round-robin output-port arbiter for the NOC router. It generalises the fixed per-direction arbiters to NUM_PORTS inputs and one configurable output PORT_ID. It adds three things the fixed arbiters lack: a rotating-pointer fairness scheme, packet-level grant locking (hold until tail flit), and an internal downstream credit counter. One instance sits in front of each output crossbar leg and drives the crossbar select.

Parameters:
NUM_PORTS, 5, number of router input ports (N,S,W,E,L = 0..4)
PORT_ID, 2, index of the output this arbiter owns; input PORT_ID is never granted (no U-turn)
ADDR_W, 3, width of each next-hop address field
CREDIT_DEPTH, 4, downstream buffer depth; credit counter reset/max value
IDX_W, $clog2(NUM_PORTS), grant index width (derived)
CRED_W, $clog2(CREDIT_DEPTH+1), credit counter width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid_i  in  NUM_PORTS  per-input flit valid
req_nexthop_addr_i  in  NUM_PORTS*ADDR_W  per-input next-hop address; slice i = [i*ADDR_W +: ADDR_W]
req_tail_i  in  NUM_PORTS  per-input flit is tail (single-flit packet: head and tail both set)
downstream_credit_i  in  1  one-cycle pulse: one downstream buffer slot freed
grant_onehot_o  out  NUM_PORTS  one-hot grant; flit of the granted input transfers this cycle
grant_idx_o  out  IDX_W  binary index of the winner; PORT_ID when no grant (crossbar default)
grant_valid_o  out  1  OR of grant_onehot_o
credit_count_o  out  CRED_W  current downstream credits
locked_o  out  1  arbiter is mid-packet, owner held
credit_overflow_o  out  1  sticky error: credit returned while counter already at CREDIT_DEPTH

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Desire: desire[i] = req_valid_i[i] & (addr_i == PORT_ID) & (i != PORT_ID).
- Registered state: rr_ptr (IDX_W), lock (1), owner (IDX_W), credits (CRED_W), overflow (1).
- Reset values: rr_ptr=0, lock=0, owner=0, credits=CREDIT_DEPTH, overflow=0.
- Outputs while reset is high: grant_onehot_o=0, grant_valid_o=0, grant_idx_o=PORT_ID, locked_o=0, credit_overflow_o=0, credit_count_o=CREDIT_DEPTH.
- Grant is combinational from registered state plus current inputs. Latency is zero: the transfer happens in the cycle the grant is asserted.
- can_send = (credits != 0).
- Unlocked: the winner is the first i with desire[i], scanning rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_PORTS (not modulo 2^IDX_W). Grant only if a winner exists and can_send.
- Locked: grant owner only if desire[owner] & can_send. Other inputs are blocked even when owner is idle (a bubble inside the packet).
- Transfer: xfer = grant_valid_o. Per transfer:
  - xfer & !req_tail_i[winner]: lock<=1, owner<=winner.
  - xfer & req_tail_i[winner]: lock<=0, rr_ptr<=(winner+1) mod NUM_PORTS.
- Pointer: rr_ptr advances only on a tail transfer. It never moves mid-packet or on idle cycles.
- Credits: credits decrement on xfer and increment on downstream_credit_i.
  - Both in the same cycle: unchanged.
  - Increment at CREDIT_DEPTH without xfer: count stays, overflow<=1 (sticky until reset).
  - Decrement below 0 is impossible by construction, since a grant requires credits>0.
- Stall: with credits=0 no grant is issued. Lock and rr_ptr hold. The owner resumes when a credit returns. The credit pulse is visible as credits=1 in the next cycle, so the grant comes 1 cycle after the pulse.
- Reset mid-packet: lock clears, pointer returns to 0, credits restore to CREDIT_DEPTH. Upstream is expected to be flushed by the same reset.
- Address change: if owner's address changes mid-packet, desire[owner] drops and the arbiter holds lock (protocol error, not recovered).

Decomposition:
- noc_arb_pkg: port index localparams (PORT_N=0, PORT_S=1, PORT_W=2, PORT_E=3, PORT_L=4) and the NUM_PORTS default.
- Sub-module rr_pick: combinational rotate-and-priority-encode. Inputs: desire vector, rr_ptr. Outputs: found, winner index. Wrap handled by doubling the vector and masking.
- Credit counter and lock FSM (UNLOCKED/LOCKED) stay inline in rr_output_arbiter.

Test Plan:
- Reset then idle → grant_valid_o=0, grant_idx_o=2, credit_count_o=4, locked_o=0.
- Inputs 0,1,3,4 all send single-flit packets to addr 2 for 4 cycles → grants 0,1,3,4 in order; rr_ptr ends at 0; credits drop to 0.
- Input 1 sends a 3-flit packet (tail on flit 3) while input 3 is continuously requesting → grants 1,1,1 then 3; locked_o is high for cycles 1-2.
- credits=0 and input 4 requesting; pulse downstream_credit_i once → no grant that cycle, grant to 4 the next cycle, credits return to 0 after.
- downstream_credit_i and xfer in the same cycle at credits=2 → credits stay 2; a credit pulse at credits=4 with no xfer → credit_overflow_o=1 and stays high.
- Input 2 requests addr 2 alone → never granted; reset asserted mid 3-flit packet → locked_o=0, rr_ptr=0, credits=4 next cycle.
